pat_sequencer: RTL and testbench
================================

# pat_sequencer

Parametrised instruction sequencer for the pattern processor: owns the program counter, a hardware call/return stack, and a single-level hardware loop counter. Sits between the instruction decoder, which supplies one-hot op strobes and immediates, and the instruction memory address port. It replaces the purely combinational next-PC logic with a registered unit that makes `call`/`return` real and reports stack faults.

## Interface
Parameters:
- I_ADR_WIDTH, 10, instruction address width; PC arithmetic is modulo 2^I_ADR_WIDTH
- OFFSET_WIDTH, 8, branch offset width; zero-extended to I_ADR_WIDTH
- STACK_DEPTH, 8, call stack entries (≥2); DW = $clog2(STACK_DEPTH+1)
- LOOP_WIDTH, 8, loop counter width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  advance; low = all state holds
- op_bf  in  1  branch forward: pc + offset
- op_bb  in  1  branch back: pc − offset
- op_call  in  1  push pc+1, jump to target
- op_return  in  1  pop, jump to popped address
- op_loop_set  in  1  load loop counter from loop_count
- op_loop_br  in  1  decrement-and-branch-back
- offset  in  OFFSET_WIDTH  branch displacement
- target  in  I_ADR_WIDTH  absolute call target
- loop_count  in  LOOP_WIDTH  loop reload value
- clear_err  in  1  clear sticky fault flags
- pc  out  I_ADR_WIDTH  current program counter (registered)
- depth  out  DW  stack occupancy, 0..STACK_DEPTH
- stack_full  out  1  depth == STACK_DEPTH
- stack_empty  out  1  depth == 0
- overflow  out  1  sticky: call attempted while full
- underflow  out  1  sticky: return attempted while empty
- loop_cnt  out  LOOP_WIDTH  current loop counter
- loop_active  out  1  loop_cnt != 0

## Operation
- Reset: pc=RESET_PC, depth=0, loop_cnt=0, overflow=0, underflow=0; stack contents don't-care. Hence stack_empty=1, stack_full=0, loop_active=0.
- Decoder drives at most one op strobe. If several are asserted, priority is call > return > bf > bb > loop_br > loop_set; only the winner acts. No strobe: pc <= pc+1.
- call, not full: stack[depth] <= pc+1, depth+1, pc <= target.
- call, full: overflow <= 1, no push, pc <= pc+1; stack is unchanged.
- return, not empty: pc <= stack[depth−1], depth−1.
- return, empty: underflow <= 1, pc <= pc+1.
- bf: pc <= pc + offset. bb: pc <= pc − offset. Both wrap modulo 2^I_ADR_WIDTH; offset=0 is a self-loop.
- loop_set: loop_cnt <= loop_count, pc <= pc+1.
- loop_br, loop_cnt != 0: loop_cnt−1, pc <= pc − offset (taken). loop_br, loop_cnt == 0: pc <= pc+1 (fall through), counter stays 0. A loop_count of N therefore executes the body N+1 times.
- Loop counter is single-level. call/return do not save or restore it.
- clear_err clears both sticky flags. If a new fault occurs in the same cycle, set wins.
- en=0: pc, stack, depth, loop_cnt and flags all hold. clear_err is ignored.

## Timing
- All state updates on the rising clk edge where en=1. Ops are sampled the same edge; pc reflects the op one cycle later, so the single-cycle next-PC latency matches the existing core.
- All outputs are registered or derived combinationally from registers only; there is no input-to-output combinational path.
- Stack read for return uses the current depth, so a call followed immediately by a return on the next cycle returns the just-pushed address.
- Reset asserted mid-sequence immediately forces the reset values listed above, independent of clk and en. The first op is accepted on the first rising edge after reset deasserts.

## Test plan
- Reset then 5 idle cycles with en=1 -> pc 0,1,2,3,4,5; depth=0, stack_empty=1.
- pc=0x3F0, op_bf offset=0x20 -> pc=0x010 (wrap). Then op_bb offset=0x11 -> pc=0x3FF.
- Nested calls: pc=5 call target=0x100; at 0x100 call target=0x200; then 2 returns -> pc 0x100→0x200→0x101→0x006; depth 0→1→2→1→0.
- STACK_DEPTH=8: 8 calls -> stack_full=1. 9th call at pc=0x50 -> overflow=1, pc=0x51, depth=8. clear_err -> overflow=0. 8 returns restore the pushed addresses in LIFO order, then a 9th return -> underflow=1, pc advances by 1.
- loop_set loop_count=3 at pc=10; body 11..12; loop_br offset=2 at 13 -> branch taken 3 times, body runs 4 times, final pc=14, loop_cnt=0.
- Simultaneous op_call and op_bf -> call wins. en=0 for 3 cycles with op_call asserted -> pc and depth unchanged. Reset asserted mid-loop with depth=3 -> pc=RESET_PC, depth=0, loop_cnt=0 before the next edge.

Source files
------------

// File: rtl/pat_sequencer.sv
// pat_sequencer: registered next-PC unit for the pattern processor.
// Owns the program counter, a hardware call/return stack and a single-level
// hardware loop counter. The decoder supplies one-hot op strobes plus
// immediates; pc drives the instruction memory address port.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   en                  advance; low freezes every piece of state
//   op_*                decoder op strobes (call > return > bf > bb > loop_br > loop_set)
//   offset, target      branch displacement (zero-extended), absolute call target
//   loop_count          loop counter reload value
//   clear_err           clear sticky overflow/underflow (a same-cycle fault wins)
//   pc                  registered program counter
//   depth               stack occupancy 0..STACK_DEPTH
//   stack_full/empty    occupancy flags
//   overflow/underflow  sticky stack fault flags
//   loop_cnt            current loop counter
//   loop_active         loop_cnt != 0
module pat_sequencer #(
    parameter int unsigned I_ADR_WIDTH  = 10,
    parameter int unsigned OFFSET_WIDTH = 8,
    parameter int unsigned STACK_DEPTH  = 8,
    parameter int unsigned LOOP_WIDTH   = 8,
    parameter int unsigned RESET_PC     = 0,
    localparam int unsigned DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    op_bf,
    input  logic                    op_bb,
    input  logic                    op_call,
    input  logic                    op_return,
    input  logic                    op_loop_set,
    input  logic                    op_loop_br,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [I_ADR_WIDTH-1:0]  target,
    input  logic [LOOP_WIDTH-1:0]   loop_count,
    input  logic                    clear_err,
    output logic [I_ADR_WIDTH-1:0]  pc,
    output logic [DW-1:0]           depth,
    output logic                    stack_full,
    output logic                    stack_empty,
    output logic                    overflow,
    output logic                    underflow,
    output logic [LOOP_WIDTH-1:0]   loop_cnt,
    output logic                    loop_active
);

    // Index width of the stack array; depth itself needs one more code for "full".
    localparam int unsigned AW = $clog2(STACK_DEPTH);

    logic [I_ADR_WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]          depth_q, depth_d;
    logic [LOOP_WIDTH-1:0]  lcnt_q, lcnt_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;

    logic [I_ADR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [I_ADR_WIDTH-1:0] pc_inc;
    logic [I_ADR_WIDTH-1:0] off_ext;
    logic [DW-1:0]          depth_m1;
    logic [AW-1:0]          wr_idx;
    logic [AW-1:0]          rd_idx;
    logic                   full;
    logic                   empty;
    logic                   push;

    assign pc_inc   = pc_q + I_ADR_WIDTH'(1);
    assign off_ext  = I_ADR_WIDTH'(offset);
    assign depth_m1 = depth_q - DW'(1);
    assign wr_idx   = depth_q[AW-1:0];
    // Read at the current depth, so a call followed by a return yields the fresh push.
    assign rd_idx   = depth_m1[AW-1:0];
    assign full     = (depth_q == DW'(STACK_DEPTH));
    assign empty    = (depth_q == '0);

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        lcnt_d  = lcnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;

        if (en) begin
            pc_d = pc_inc;
            // Clear first so a fault raised below in the same cycle wins.
            if (clear_err) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end

            if (op_call) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    depth_d = depth_q + DW'(1);
                    pc_d    = target;
                end
            end else if (op_return) begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    depth_d = depth_m1;
                    pc_d    = stack_mem[rd_idx];
                end
            end else if (op_bf) begin
                pc_d = pc_q + off_ext;
            end else if (op_bb) begin
                pc_d = pc_q - off_ext;
            end else if (op_loop_br) begin
                if (lcnt_q != '0) begin
                    lcnt_d = lcnt_q - LOOP_WIDTH'(1);
                    pc_d   = pc_q - off_ext;
                end
            end else if (op_loop_set) begin
                lcnt_d = loop_count;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= I_ADR_WIDTH'(RESET_PC);
            depth_q <= '0;
            lcnt_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            lcnt_q  <= lcnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents need no reset; occupancy is tracked by depth_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

    assign pc          = pc_q;
    assign depth       = depth_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign loop_cnt    = lcnt_q;
    assign loop_active = (lcnt_q != '0);

endmodule

// File: tb/tb_pat_sequencer.sv
// Self-checking bench for pat_sequencer: a behavioural model computes the
// expected state for each driven step and pushes it to a scoreboard queue;
// the entry is popped and compared one clock later. Directed constant checks
// pin down the key values of each scenario.
module tb_pat_sequencer;

    localparam int unsigned AW = 10;
    localparam int unsigned OW = 8;
    localparam int unsigned SD = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned DW = $clog2(SD + 1);

    // Op vector bit order: {call, return, bf, bb, loop_br, loop_set}
    localparam logic [5:0] OP_NONE = 6'b000000;
    localparam logic [5:0] OP_CALL = 6'b100000;
    localparam logic [5:0] OP_RET  = 6'b010000;
    localparam logic [5:0] OP_BF   = 6'b001000;
    localparam logic [5:0] OP_BB   = 6'b000100;
    localparam logic [5:0] OP_LBR  = 6'b000010;
    localparam logic [5:0] OP_LSET = 6'b000001;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          op_bf, op_bb, op_call, op_return, op_loop_set, op_loop_br;
    logic [OW-1:0] offset;
    logic [AW-1:0] target;
    logic [LW-1:0] loop_count;
    logic          clear_err;
    logic [AW-1:0] pc;
    logic [DW-1:0] depth;
    logic          stack_full, stack_empty, overflow, underflow;
    logic [LW-1:0] loop_cnt;
    logic          loop_active;

    always #5 clk = ~clk;

    pat_sequencer #(
        .I_ADR_WIDTH (AW),
        .OFFSET_WIDTH(OW),
        .STACK_DEPTH (SD),
        .LOOP_WIDTH  (LW),
        .RESET_PC    (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .op_bf      (op_bf),
        .op_bb      (op_bb),
        .op_call    (op_call),
        .op_return  (op_return),
        .op_loop_set(op_loop_set),
        .op_loop_br (op_loop_br),
        .offset     (offset),
        .target     (target),
        .loop_count (loop_count),
        .clear_err  (clear_err),
        .pc         (pc),
        .depth      (depth),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .overflow   (overflow),
        .underflow  (underflow),
        .loop_cnt   (loop_cnt),
        .loop_active(loop_active)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] depth;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          unf;
        logic [LW-1:0] lcnt;
        logic          lact;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model state
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic          m_ovf;
    logic          m_unf;
    logic [LW-1:0] m_lcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = '0;
        m_stk  = {};
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_lcnt = '0;
    endtask

    task automatic model_step(input logic [5:0] ops, input logic [OW-1:0] off,
                              input logic [AW-1:0] tgt, input logic [LW-1:0] lc,
                              input logic clr, input logic e);
        logic [AW-1:0] off_w;
        off_w = AW'(off);
        if (!e) return;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ops[5]) begin
            if (m_stk.size() == SD) begin
                m_ovf = 1'b1;
                m_pc  = m_pc + 1'b1;
            end else begin
                m_stk.push_back(m_pc + 1'b1);
                m_pc = tgt;
            end
        end else if (ops[4]) begin
            if (m_stk.size() == 0) begin
                m_unf = 1'b1;
                m_pc  = m_pc + 1'b1;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (ops[3]) begin
            m_pc = m_pc + off_w;
        end else if (ops[2]) begin
            m_pc = m_pc - off_w;
        end else if (ops[1]) begin
            if (m_lcnt != 0) begin
                m_lcnt = m_lcnt - 1'b1;
                m_pc   = m_pc - off_w;
            end else begin
                m_pc = m_pc + 1'b1;
            end
        end else begin
            if (ops[0]) m_lcnt = lc;
            m_pc = m_pc + 1'b1;
        end
    endtask

    task automatic step(input logic [5:0] ops, input logic [OW-1:0] off,
                        input logic [AW-1:0] tgt, input logic [LW-1:0] lc,
                        input logic clr, input logic e);
        exp_t x;
        {op_call, op_return, op_bf, op_bb, op_loop_br, op_loop_set} = ops;
        offset     = off;
        target     = tgt;
        loop_count = lc;
        clear_err  = clr;
        en         = e;
        model_step(ops, off, tgt, lc, clr, e);
        x.pc    = m_pc;
        x.depth = DW'(m_stk.size());
        x.full  = (m_stk.size() == SD);
        x.empty = (m_stk.size() == 0);
        x.ovf   = m_ovf;
        x.unf   = m_unf;
        x.lcnt  = m_lcnt;
        x.lact  = (m_lcnt != 0);
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("pc", 32'(pc), 32'(x.pc));
        check("depth", 32'(depth), 32'(x.depth));
        check("stack_full", 32'(stack_full), 32'(x.full));
        check("stack_empty", 32'(stack_empty), 32'(x.empty));
        check("overflow", 32'(overflow), 32'(x.ovf));
        check("underflow", 32'(underflow), 32'(x.unf));
        check("loop_cnt", 32'(loop_cnt), 32'(x.lcnt));
        check("loop_active", 32'(loop_active), 32'(x.lact));
    endtask

    task automatic idle();
        step(OP_NONE, 8'h00, 10'h000, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic drive_quiet();
        {op_call, op_return, op_bf, op_bb, op_loop_br, op_loop_set} = OP_NONE;
        offset     = '0;
        target     = '0;
        loop_count = '0;
        clear_err  = 1'b0;
        en         = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive_quiet();
        model_reset();
        #12;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_depth", 32'(depth), 32'h0);
        check("rst_empty", 32'(stack_empty), 32'h1);
        check("rst_full", 32'(stack_full), 32'h0);
        check("rst_loop_active", 32'(loop_active), 32'h0);
        reset = 1'b0;

        // Idle counting
        repeat (5) idle();
        check("idle_pc5", 32'(pc), 32'h5);

        // Branch wrap at the top of the address space
        step(OP_CALL, 8'h00, 10'h3F0, 8'h00, 1'b0, 1'b1);
        step(OP_BF, 8'h20, 10'h000, 8'h00, 1'b0, 1'b1);
        check("bf_wrap", 32'(pc), 32'h010);
        step(OP_BB, 8'h11, 10'h000, 8'h00, 1'b0, 1'b1);
        check("bb_wrap", 32'(pc), 32'h3FF);
        step(OP_RET, 8'h00, 10'h000, 8'h00, 1'b0, 1'b1);
        check("ret_after_wrap", 32'(pc), 32'h006);

        // Nested calls and returns
        step(OP_CALL, 8'h00, 10'h100, 8'h00, 1'b0, 1'b1);
        check("nest_pc1", 32'(pc), 32'h100);
        step(OP_CALL, 8'h00, 10'h200, 8'h00, 1'b0, 1'b1);
        check("nest_pc2", 32'(pc), 32'h200);
        check("nest_depth2", 32'(depth), 32'h2);
        step(OP_RET, 8'h00, 10'h000, 8'h00, 1'b0, 1'b1);
        check("nest_ret1", 32'(pc), 32'h101);
        step(OP_RET, 8'h00, 10'h000, 8'h00, 1'b0, 1'b1);
        check("nest_ret2", 32'(pc), 32'h007);

        // Fill the stack, overflow, clear, drain, underflow
        for (int k = 0; k < 8; k++) begin
            step(OP_CALL, 8'h00, (k == 7) ? 10'h050 : 10'(10'h080 + k * 16), 8'h00, 1'b0, 1'b1);
        end
        check("fill_full", 32'(stack_full), 32'h1);
        step(OP_CALL, 8'h00, 10'h300, 8'h00, 1'b0, 1'b1);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_pc", 32'(pc), 32'h051);
        check("ovf_depth", 32'(depth), 32'h8);
        step(OP_NONE, 8'h00, 10'h000, 8'h00, 1'b1, 1'b0);  // clear ignored while en=0
        check("clr_ignored", 32'(overflow), 32'h1);
        step(OP_NONE, 8'h00, 10'h000, 8'h00, 1'b1, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'h0);
        repeat (8) step(OP_RET, 8'h00, 10'h000, 8'h00, 1'b0, 1'b1);
        check("drain_pc", 32'(pc), 32'h008);
        step(OP_RET, 8'h00, 10'h000, 8'h00, 1'b0, 1'b1);
        check("unf_flag", 32'(underflow), 32'h1);
        check("unf_pc", 32'(pc), 32'h009);
        step(OP_RET, 8'h00, 10'h000, 8'h00, 1'b1, 1'b1);   // set wins over clear
        check("unf_set_wins", 32'(underflow), 32'h1);
        step(OP_NONE, 8'h00, 10'h000, 8'h00, 1'b1, 1'b1);

        // Hardware loop: body 11..12, loop_br at 13, count 3
        step(OP_CALL, 8'h00, 10'd10, 8'h00, 1'b0, 1'b1);
        step(OP_LSET, 8'h00, 10'h000, 8'd3, 1'b0, 1'b1);
        for (int it = 0; it < 4; it++) begin
            idle();
            idle();
            step(OP_LBR, 8'd2, 10'h000, 8'h00, 1'b0, 1'b1);
        end
        check("loop_exit_pc", 32'(pc), 32'd14);
        check("loop_exit_cnt", 32'(loop_cnt), 32'h0);
        step(OP_RET, 8'h00, 10'h000, 8'h00, 1'b0, 1'b1);

        // Priority between simultaneous strobes
        step(OP_CALL | OP_BF, 8'h40, 10'h222, 8'h00, 1'b0, 1'b1);
        check("prio_call_pc", 32'(pc), 32'h222);
        step(OP_RET | OP_BF, 8'h40, 10'h000, 8'h00, 1'b0, 1'b1);
        step(OP_BF | OP_BB, 8'h04, 10'h000, 8'h00, 1'b0, 1'b1);
        step(OP_BB | OP_LBR, 8'h03, 10'h000, 8'h00, 1'b0, 1'b1);
        step(OP_LBR | OP_LSET, 8'h05, 10'h000, 8'h09, 1'b0, 1'b1);
        check("prio_lset_loses", 32'(loop_cnt), 32'h0);

        // en=0 freezes everything even with a call asserted
        repeat (3) step(OP_CALL, 8'h00, 10'h123, 8'h00, 1'b0, 1'b0);
        check("hold_depth", 32'(depth), 32'h0);

        // Reset mid-loop with depth 3
        step(OP_CALL, 8'h00, 10'h030, 8'h00, 1'b0, 1'b1);
        step(OP_CALL, 8'h00, 10'h040, 8'h00, 1'b0, 1'b1);
        step(OP_CALL, 8'h00, 10'h050, 8'h00, 1'b0, 1'b1);
        step(OP_LSET, 8'h00, 10'h000, 8'd5, 1'b0, 1'b1);
        step(OP_LBR, 8'd1, 10'h000, 8'h00, 1'b0, 1'b1);
        check("pre_rst_depth", 32'(depth), 32'h3);
        drive_quiet();
        #3 reset = 1'b1;
        #1;
        check("async_rst_pc", 32'(pc), 32'h0);
        check("async_rst_depth", 32'(depth), 32'h0);
        check("async_rst_lcnt", 32'(loop_cnt), 32'h0);
        #1 reset = 1'b0;
        model_reset();
        idle();
        check("post_rst_pc", 32'(pc), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
